// File: rtl/piso_defs.sv
// Shared definitions for the PISO shifter: FSM state encoding and a helper that
// sizes the bit counter from the shift-register width.
package piso_defs;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Counter holds WIDTH-1 down to 0; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shifter_if.sv
// Load/serial bus of the PISO shifter.
//   start, din, dir : load request, parallel word and shift order (master -> slave)
//   sout            : serial data bit (slave -> master)
//   busy, done      : word in flight / one-cycle end-of-word pulse (slave -> master)
//   q               : shift-register contents for observation (slave -> master)
interface piso_shifter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             dir;
    logic             sout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;

    modport master (
        output start, din, dir,
        input  sout, busy, done, q
    );

    modport slave (
        input  start, din, dir,
        output sout, busy, done, q
    );
endinterface

// File: rtl/dff_ar.sv
// Parameterized-width D register with asynchronous active-high reset to zero.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears q_o
//   d_i : next value
//   q_o : registered value
module dff_ar #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= '0;
        end else begin
            q_o <= d_i;
        end
    end
endmodule

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter. A word accepted on start is shifted out one bit
// per cycle, LSB or MSB first as selected by dir at load time, followed by a
// one-cycle done pulse. A start seen during that done cycle reloads immediately.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : piso_shifter_if slave (start/din/dir in; sout/busy/done/q out)
module piso_shifter
    import piso_defs::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    piso_shifter_if.slave  bus
);
    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [StateW-1:0] state_raw;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              dir_q, dir_d;

    logic              sout;
    logic              busy;
    logic              done;

    // State register
    dff_ar #(.Width(StateW)) u_state_reg (
        .clk (clk),
        .rst (rst),
        .d_i (state_d),
        .q_o (state_raw)
    );
    assign state_q = state_e'(state_raw);

    dff_ar #(.Width(WIDTH)) u_shift_reg (
        .clk (clk),
        .rst (rst),
        .d_i (q_d),
        .q_o (q_q)
    );

    dff_ar #(.Width(CntW)) u_cnt_reg (
        .clk (clk),
        .rst (rst),
        .d_i (cnt_d),
        .q_o (cnt_q)
    );

    dff_ar #(.Width(1)) u_dir_reg (
        .clk (clk),
        .rst (rst),
        .d_i (dir_d),
        .q_o (dir_q)
    );

    // Next-state and shift logic
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    q_d     = bus.din;
                    dir_d   = bus.dir;
                    cnt_d   = CntW'(WIDTH - 1);
                    state_d = StShift;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                // Inputs are deliberately ignored here; dir_q fixes the order.
                if (cnt_q != '0) begin
                    q_d   = dir_q ? {q_q[WIDTH-2:0], 1'b0} : {1'b0, q_q[WIDTH-1:1]};
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    q_d     = '0;
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        sout = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StShift: begin
                busy = 1'b1;
                sout = dir_q ? q_q[WIDTH-1] : q_q[0];
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                sout = 1'b0;
            end
        endcase
    end

    assign bus.sout = sout;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.q    = q_q;
endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter (WIDTH=8): directed loads push expected serial bits and
// done pulses, tagged with the cycle they must appear in, into a scoreboard queue;
// a monitor pops and compares whenever the DUT shows busy or done.
module tb_piso_shifter;
    localparam int unsigned W = 8;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    bit   finish_req;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    piso_shifter_if #(.WIDTH(W)) bus ();

    piso_shifter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // seq[0] is the first bit expected on sout; cycle 1 of the word is 'base'.
    task automatic push_word(input int base, input logic [0:7] seq, input int nbits);
        exp_t e;
        for (int k = 0; k < nbits; k++) begin
            e.cyc = base + k;
            e.is_done = 1'b0;
            e.val = seq[k];
            exp_q.push_back(e);
        end
        if (nbits == 8) begin
            e.cyc = base + 8;
            e.is_done = 1'b1;
            e.val = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert start for exactly one accepting edge; returns in cycle 1 of the word.
    task automatic issue(input logic [7:0] d, input logic dr, input logic [0:7] seq);
        bus.start = 1'b1;
        bus.din   = d;
        bus.dir   = dr;
        push_word(cyc + 1, seq, 8);
        next_cycle(1);
        bus.start = 1'b0;
    endtask

    // Stimulus
    initial begin
        int c0;
        rst        = 1'b0;
        finish_req = 1'b0;
        bus.start  = 1'b0;
        bus.din    = '0;
        bus.dir    = 1'b0;
        #2 rst = 1'b1;
        next_cycle(2);
        rst = 1'b0;

        // Scenario 1: idle with start low
        next_cycle(3);

        // Scenario 2: C1, LSB first
        issue(8'hC1, 1'b0, 8'b1000_0011);
        next_cycle(9);

        // Scenario 3: C1, MSB first
        issue(8'hC1, 1'b1, 8'b1100_0001);
        next_cycle(9);

        // Scenario 4: inputs churn mid-word and must be ignored
        issue(8'hFF, 1'b0, 8'b1111_1111);
        for (int k = 2; k <= 6; k++) begin
            next_cycle(1);
            bus.start = 1'b1;
            bus.dir   = ~bus.dir;
            bus.din   = 8'h00;
        end
        next_cycle(1);
        bus.start = 1'b0;
        bus.dir   = 1'b0;
        next_cycle(4);

        // Scenario 5: async reset in cycle 4 aborts the word, no done pulse
        bus.start = 1'b1;
        bus.din   = 8'hAA;
        bus.dir   = 1'b0;
        push_word(cyc + 1, 8'b0101_0101, 3);
        next_cycle(1);
        bus.start = 1'b0;
        next_cycle(3);
        #2 rst = 1'b1;
        next_cycle(2);

        // Scenario 6: start held across reset release; back-to-back words
        rst       = 1'b0;
        bus.start = 1'b1;
        bus.din   = 8'h0F;
        bus.dir   = 1'b0;
        c0 = cyc;
        push_word(c0 + 1, 8'b1111_0000, 8);
        push_word(c0 + 10, 8'b1111_0000, 8);
        push_word(c0 + 19, 8'b1111_0000, 8);
        next_cycle(19);
        bus.start = 1'b0;
        next_cycle(10);
        finish_req = 1'b1;
    end

    // Monitor / scoreboard: the only process touching the counters.
    initial begin
        logic prev_rst;
        exp_t e;
        checks   = 0;
        errors   = 0;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst && !prev_rst) begin
                prev_rst = 1'b1;
                #1;
                checks++;
                if (bus.q !== '0 || bus.sout !== 1'b0 || bus.busy !== 1'b0
                    || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset: q=%h sout=%b busy=%b done=%b, required all 0",
                             bus.q, bus.sout, bus.busy, bus.done);
                end
            end else begin
                prev_rst = rst;
                if (finish_req) begin
                    checks++;
                    if (exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL drain: %0d expected outputs never seen, required 0",
                                 exp_q.size());
                    end
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end else if (bus.busy === 1'b1 || bus.done === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: cyc=%0d busy=%b done=%b, required idle",
                                 cyc, bus.busy, bus.done);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || bus.done !== e.is_done || bus.busy !== !e.is_done
                            || bus.sout !== e.val) begin
                            errors++;
                            $display({"FAIL serial_out: got cyc=%0d busy=%b done=%b sout=%b, ",
                                      "required cyc=%0d busy=%b done=%b sout=%b"},
                                     cyc, bus.busy, bus.done, bus.sout,
                                     e.cyc, !e.is_done, e.is_done, e.val);
                        end
                    end
                end else begin
                    checks++;
                    if (bus.sout !== 1'b0 || bus.q !== '0 || bus.busy !== 1'b0
                        || bus.done !== 1'b0
                        || (exp_q.size() != 0 && exp_q[0].cyc <= cyc)) begin
                        errors++;
                        $display({"FAIL idle: cyc=%0d sout=%b q=%h busy=%b done=%b pending=%0d, ",
                                  "required zeros and no overdue output"},
                                 cyc, bus.sout, bus.q, bus.busy, bus.done, exp_q.size());
                    end
                end
            end
        end
    end
endmodule

// File: doc/piso_shifter.md
PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning shift-register width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  input  1  load request; sampled on rising clk edge.
REQ-005 The block SHALL have port din  input  WIDTH  parallel word captured on an accepted start.
REQ-006 The block SHALL have port dir  input  1  shift order, 0 = LSB first, 1 = MSB first; captured with din.
REQ-007 The block SHALL have port sout  output  1  serial data bit.
REQ-008 The block SHALL have port busy  output  1  high while a word is being shifted out.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse after the last bit.
REQ-010 The block SHALL have port q  output  WIDTH  current shift-register contents, for observation.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE; encodings are 2-bit constants.
REQ-012 In IDLE with start=1 at a rising edge: q <= din, dir captured, cnt <= WIDTH-1, state -> SHIFT.
REQ-013 In IDLE with start=0: all registers hold.
REQ-014 In SHIFT: busy=1; sout = q[0] if captured dir=0, else q[WIDTH-1]; combinational from q.
REQ-015 Each SHIFT edge with cnt!=0: q shifts one place toward the output end, vacated bit filled with 0, cnt decrements.
REQ-016 SHIFT edge with cnt==0: state -> DONE; q cleared to 0.
REQ-017 Latency: first bit on sout in the cycle after start is accepted; WIDTH bits on WIDTH consecutive cycles; done high in cycle WIDTH+1.
REQ-018 In DONE: done=1, busy=0, sout=0, for exactly one cycle.
REQ-019 DONE with start=1 SHALL behave as in IDLE (accept and load): back-to-back words with a one-cycle gap.
REQ-020 DONE with start=0 SHALL go to IDLE.
REQ-021 start, din and dir SHALL be ignored while in SHIFT; changes to dir mid-word have no effect.
REQ-022 In IDLE: sout=0, busy=0, done=0.
REQ-023 cnt width SHALL be clog2(WIDTH); no wrap below 0 is reachable.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force the following: state=IDLE, q=0, cnt=0, captured dir=0, sout=0, busy=0, done=0.
REQ-025 rst asserted mid-SHIFT SHALL abort the word with no done pulse.
REQ-026 On the first edge after rst deassertion, start SHALL be accepted normally.

Structure
REQ-027 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in the shared package/include piso_defs.
REQ-028 One sub-module dff_ar SHALL be used for all state bits: a parameterized-width D register with async active-high reset.
REQ-029 The next-state and shift logic SHALL be purely combinational and SHALL feed dff_ar instances.

Verification (WIDTH=8)
REQ-030 Scenario 1: rst pulse, then idle with start=0 for 3 cycles -> q=0, sout=0, busy=0, done=0 throughout.
REQ-031 Scenario 2: start=1, din=8'hC1, dir=0 -> sout=1,0,0,0,0,0,1,1 over cycles 1-8; busy high in cycles 1-8; done=1 in cycle 9 only.
REQ-032 Scenario 3: start=1, din=8'hC1, dir=1 -> sout=1,1,0,0,0,0,0,1; same busy and done timing as Scenario 2.
REQ-033 Scenario 4: load 8'hFF, then toggle dir and hold start=1 during cycles 2-6 -> output is eight 1s; no reload occurs; done appears in cycle 9.
REQ-034 Scenario 5: load 8'hAA, assert rst asynchronously mid-cycle 4 -> q, sout and busy drop to 0 at once; no done pulse.
REQ-035 Scenario 6: start held at 1 continuously with din=8'h0F -> done pulse and reload occur together; the next word starts in the following cycle; period is 9 cycles per word.
